dma_fft_framer: RTL and testbench

AXI-Stream framing stage between the AXI DMA MM2S channel and the FFT core in the dma_ex_fft design. It regenerates TLAST at a runtime-selectable FFT length and tags each frame with a round-robin channel index on TUSER. It also flags DMA transfers whose TLAST disagrees with the configured length. It extends the fixed single-channel, fixed-length DMA→FFT path to NUM_CH interleaved frame channels and a variable transform size.

---
 rtl/dma_fft_pkg.sv | 18 +
 rtl/axis_skid_buf.sv | 52 +++++
 rtl/dma_fft_framer.sv | 132 +++++++++++++
 tb/tb_dma_fft_framer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_fft_pkg.sv
// Shared types and constants for the DMA -> FFT framing stage.
package dma_fft_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam int MIN_LOG2N   = 4;
  localparam int FRAME_CNT_W = 32;

  // Channel index width; a single channel still needs a 1-bit TUSER.
  function automatic int ch_width(input int num_ch);
    return (num_ch <= 2) ? 1 : $clog2(num_ch);
  endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry AXI-Stream register slice. in_ready is a flop, so there is no
// combinational path from out_ready back to in_ready.
module axis_skid_buf #(
  parameter int PW = 35
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] out_data,
  output logic          empty
);

  logic [PW-1:0] sk_data;
  logic          sk_valid;

  assign empty = !out_valid && !sk_valid;

  // Main register feeds the output; the skid entry catches the beat that
  // arrives in the cycle the consumer stalls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      sk_data   <= '0;
      sk_valid  <= 1'b0;
      in_ready  <= 1'b1;
    end else if (in_valid && in_ready) begin
      if (out_valid && !out_ready) begin
        sk_data  <= in_data;
        sk_valid <= 1'b1;
        in_ready <= 1'b0;
      end else begin
        out_data  <= in_data;
        out_valid <= 1'b1;
      end
    end else if (out_ready) begin
      if (sk_valid) begin
        out_data  <= sk_data;
        out_valid <= 1'b1;
        sk_valid  <= 1'b0;
        in_ready  <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/dma_fft_framer.sv
// AXI-Stream framer between DMA MM2S and the FFT: regenerates TLAST at a
// runtime FFT length, tags frames with a round-robin channel on TUSER and
// flags DMA TLAST that disagrees with the configured length.
// Optional: define DMA_FFT_FRAMER_STATS_EN to build the frame counter;
// otherwise frame_cnt is tied to zero.
module dma_fft_framer
  import dma_fft_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int MAX_LOG2N = 12,
  parameter int NUM_CH    = 4,
  parameter int CH_W      = ch_width(NUM_CH)
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic                         cfg_en,
  input  logic [$clog2(MAX_LOG2N+1)-1:0] cfg_log2n,
  input  logic                         err_clr,
  input  logic [DATA_W-1:0]            s_axis_tdata,
  input  logic                         s_axis_tvalid,
  output logic                         s_axis_tready,
  input  logic                         s_axis_tlast,
  output logic [DATA_W-1:0]            m_axis_tdata,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic                         m_axis_tlast,
  output logic [CH_W-1:0]              m_axis_tuser,
  output logic                         busy,
  output logic                         err_early_last,
  output logic                         err_missing_last,
  output logic [FRAME_CNT_W-1:0]       frame_cnt
);

  localparam int LW    = $clog2(MAX_LOG2N + 1);
  localparam int CNT_W = MAX_LOG2N;
  localparam int PW    = DATA_W + 1 + CH_W;

  state_t           state;
  logic [CNT_W-1:0] cnt, n_m1, cfg_n_m1;
  logic [CH_W-1:0]  ch;
  logic             run, buf_rdy, buf_empty, s_fire, at_end, out_last, cfg_ok;
  logic [PW-1:0]    buf_out;

  assign run           = (state == ST_RUN);
  assign s_axis_tready = run && buf_rdy;
  assign s_fire        = s_axis_tvalid && s_axis_tready;
  assign at_end        = (cnt == n_m1);
  assign out_last      = at_end || s_axis_tlast;
  assign cfg_ok        = (cfg_log2n >= LW'(MIN_LOG2N)) && (cfg_log2n <= LW'(MAX_LOG2N));
  assign cfg_n_m1      = CNT_W'((32'd1 << cfg_log2n) - 32'd1);
  assign busy          = (state != ST_IDLE);

  // Frame sequencing: length latch, sample counter, channel rotation.
  // An out-of-range length at a boundary keeps the previous length.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state <= ST_IDLE;
      cnt   <= '0;
      n_m1  <= '0;
      ch    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cfg_en && cfg_ok) begin
            n_m1  <= cfg_n_m1;
            cnt   <= '0;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (s_fire) begin
            if (out_last) begin
              cnt <= '0;
              ch  <= (ch == CH_W'(NUM_CH - 1)) ? '0 : ch + 1'b1;
              if (cfg_ok) n_m1 <= cfg_n_m1;
              if (!cfg_en) state <= ST_DRAIN;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (buf_empty) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Sticky TLAST mismatch flags; a new event wins over a same-cycle clear.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      err_early_last   <= 1'b0;
      err_missing_last <= 1'b0;
    end else begin
      err_early_last   <= (err_early_last && !err_clr) ||
                          (s_fire && s_axis_tlast && !at_end);
      err_missing_last <= (err_missing_last && !err_clr) ||
                          (s_fire && at_end && !s_axis_tlast);
    end
  end

`ifdef DMA_FFT_FRAMER_STATS_EN
  logic [FRAME_CNT_W-1:0] fc_q;

  // Completed-frame counter; clear has priority and the count wraps.
  always_ff @(posedge aclk) begin
    if (!aresetn)              fc_q <= '0;
    else if (err_clr)          fc_q <= '0;
    else if (s_fire && out_last) fc_q <= fc_q + 1'b1;
  end

  assign frame_cnt = fc_q;
`else
  assign frame_cnt = '0;
`endif

  axis_skid_buf #(.PW(PW)) u_skid (
    .clk       (aclk),
    .rst_n     (aresetn),
    .in_valid  (s_axis_tvalid && run),
    .in_ready  (buf_rdy),
    .in_data   ({s_axis_tdata, out_last, ch}),
    .out_valid (m_axis_tvalid),
    .out_ready (m_axis_tready),
    .out_data  (buf_out),
    .empty     (buf_empty)
  );

  assign {m_axis_tdata, m_axis_tlast, m_axis_tuser} = buf_out;

endmodule

// File: tb/tb_dma_fft_framer.sv
// Directed bench for dma_fft_framer: table of framing scenarios plus
// hand-written sequences for error timing, length change, backpressure
// and mid-frame reset.
module tb_dma_fft_framer;

  localparam int DATA_W = 32;
  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;
  localparam int PW     = DATA_W + 1 + CH_W;

  logic              aclk = 1'b0;
  logic              aresetn, cfg_en, err_clr;
  logic [3:0]        cfg_log2n;
  logic [DATA_W-1:0] s_tdata, m_tdata;
  logic              s_tvalid, s_tready, s_tlast;
  logic              m_tvalid, m_tready, m_tlast;
  logic [CH_W-1:0]   m_tuser;
  logic              busy, err_early, err_miss;
  logic [31:0]       frame_cnt;

  logic              stall = 1'b0;
  logic              rnd_ready = 1'b0;

  int checks = 0;
  int failures = 0;
  int exp_ch = 0;

  logic [PW-1:0] got_q[$];
  logic [PW-1:0] exp_q[$];

  typedef struct {
    int log2n; int nbeats; int dma_per; int exp_len; int exp_frames;
    bit exp_early; bit exp_miss;
  } vec_t;
  vec_t vecs[5];

  always #5 aclk = ~aclk;

  dma_fft_framer dut (
    .aclk(aclk), .aresetn(aresetn), .cfg_en(cfg_en), .cfg_log2n(cfg_log2n),
    .err_clr(err_clr),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .s_axis_tlast(s_tlast),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser),
    .busy(busy), .err_early_last(err_early), .err_missing_last(err_miss),
    .frame_cnt(frame_cnt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic int exp_fc(input int n);
`ifdef DMA_FFT_FRAMER_STATS_EN
    return n;
`else
    return 0;
`endif
  endfunction

  // Consumer ready: constant, stalled, or random.
  initial begin
    m_tready = 1'b0;
    forever begin
      @(posedge aclk); #1;
      m_tready = rnd_ready ? 1'($urandom_range(1)) : !stall;
    end
  end

  // Output monitor: captures handshakes and checks payload hold during stalls.
  logic          held = 1'b0;
  logic [PW-1:0] held_pl;
  always @(negedge aclk) begin
    if (!aresetn) begin
      held = 1'b0;
    end else begin
      if (held) begin
        chk("stall_valid_hold", 64'(m_tvalid), 64'd1);
        chk("stall_payload_hold", 64'({m_tdata, m_tlast, m_tuser}), 64'(held_pl));
      end
      if (m_tvalid && m_tready) got_q.push_back({m_tdata, m_tlast, m_tuser});
      held    = m_tvalid && !m_tready;
      held_pl = {m_tdata, m_tlast, m_tuser};
    end
  end

  // Offer one input beat and record what the output must show for it.
  task automatic send(input logic [31:0] d, input logic sl, input logic el);
    int t = 0;
    s_tdata = d; s_tlast = sl; s_tvalid = 1'b1;
    exp_q.push_back({d, el, CH_W'(exp_ch)});
    if (el) exp_ch = (exp_ch + 1) % NUM_CH;
    @(negedge aclk);
    while (!s_tready && t < 500) begin t++; @(negedge aclk); end
    if (!s_tready) chk("send_timeout", 64'd0, 64'd1);
    @(posedge aclk); #1;
    s_tvalid = 1'b0; s_tlast = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    @(negedge aclk);
    while ((busy || m_tvalid) && t < 2000) begin t++; @(negedge aclk); end
    if (busy || m_tvalid) chk("idle_timeout", 64'd0, 64'd1);
    @(posedge aclk); #1;
  endtask

  task automatic compare_q(input string name);
    chk($sformatf("%s_len", name), 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s_beat%0d", name, i), 64'(got_q[i]), 64'(exp_q[i]));
    got_q.delete(); exp_q.delete();
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(posedge aclk); #1;
    err_clr = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_m_tvalid"}, 64'(m_tvalid), 64'd0);
    chk({tag, "_s_tready"}, 64'(s_tready), 64'd0);
    chk({tag, "_m_tlast"},  64'(m_tlast),  64'd0);
    chk({tag, "_m_tuser"},  64'(m_tuser),  64'd0);
    chk({tag, "_m_tdata"},  64'(m_tdata),  64'd0);
    chk({tag, "_busy"},     64'(busy),     64'd0);
    chk({tag, "_err_early"}, 64'(err_early), 64'd0);
    chk({tag, "_err_miss"}, 64'(err_miss), 64'd0);
    chk({tag, "_frame_cnt"}, 64'(frame_cnt), 64'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic sl, el;
    vecs[0] = '{4, 64, 16, 16, 4, 1'b0, 1'b0};
    vecs[1] = '{5, 64, 32, 32, 2, 1'b0, 1'b0};
    vecs[2] = '{4, 32,  0, 16, 2, 1'b0, 1'b1};
    vecs[3] = '{4, 30, 10, 10, 3, 1'b1, 1'b0};
    vecs[4] = '{6, 64,  0, 64, 1, 1'b0, 1'b1};

    aresetn = 1'b0; cfg_en = 1'b0; cfg_log2n = 4'd4; err_clr = 1'b0;
    s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    check_reset_vals("reset");
    aresetn = 1'b1;
    @(posedge aclk); #1;

    // Out-of-range lengths must leave the block idle.
    cfg_log2n = 4'd13; cfg_en = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    chk("oor13_busy", 64'(busy), 64'd0);
    chk("oor13_tready", 64'(s_tready), 64'd0);
    cfg_log2n = 4'd3;
    repeat (3) @(posedge aclk);
    #1;
    chk("oor3_busy", 64'(busy), 64'd0);
    cfg_en = 1'b0;
    @(posedge aclk); #1;

    // Table-driven framing scenarios; each ends by draining to IDLE.
    for (int v = 0; v < 5; v++) begin
      cfg_log2n = 4'(vecs[v].log2n); cfg_en = 1'b1;
      for (int i = 0; i < vecs[v].nbeats; i++) begin
        sl = (vecs[v].dma_per > 0) && (((i + 1) % vecs[v].dma_per) == 0);
        el = ((i % vecs[v].exp_len) == vecs[v].exp_len - 1);
        if (i == vecs[v].nbeats - 1) cfg_en = 1'b0;
        send(32'((v << 16) | i), sl, el);
      end
      chk($sformatf("v%0d_busy_drain", v), 64'(busy), 64'd1);
      chk($sformatf("v%0d_tready_drain", v), 64'(s_tready), 64'd0);
      wait_idle();
      compare_q($sformatf("v%0d", v));
      chk($sformatf("v%0d_err_early", v), 64'(err_early), 64'(vecs[v].exp_early));
      chk($sformatf("v%0d_err_miss", v), 64'(err_miss), 64'(vecs[v].exp_miss));
      chk($sformatf("v%0d_frame_cnt", v), 64'(frame_cnt), 64'(exp_fc(vecs[v].exp_frames)));
      pulse_clr();
      chk($sformatf("v%0d_clr_early", v), 64'(err_early), 64'd0);
      chk($sformatf("v%0d_clr_miss", v), 64'(err_miss), 64'd0);
      chk($sformatf("v%0d_clr_fc", v), 64'(frame_cnt), 64'd0);
    end

    // Early TLAST at beat 9: flag visible right after the accepting edge,
    // then an early TLAST coinciding with err_clr leaves the flag set.
    cfg_log2n = 4'd4; cfg_en = 1'b1;
    for (int i = 0; i < 9; i++) send(32'h100 + 32'(i), 1'b0, 1'b0);
    chk("early_before", 64'(err_early), 64'd0);
    send(32'h109, 1'b1, 1'b1);
    chk("early_next_cycle", 64'(err_early), 64'd1);
    chk("early_no_miss", 64'(err_miss), 64'd0);
    pulse_clr();
    chk("early_cleared", 64'(err_early), 64'd0);
    for (int i = 0; i < 9; i++) send(32'h200 + 32'(i), 1'b0, 1'b0);
    err_clr = 1'b1;
    send(32'h209, 1'b1, 1'b1);
    err_clr = 1'b0;
    chk("clr_vs_event_flag", 64'(err_early), 64'd1);
    chk("clr_vs_event_fc", 64'(frame_cnt), 64'd0);
    for (int i = 0; i < 16; i++) begin
      if (i == 15) cfg_en = 1'b0;
      send(32'h300 + 32'(i), i == 15, i == 15);
    end
    wait_idle();
    compare_q("early_seq");
    pulse_clr();

    // Length change 4 -> 6 mid-frame applies only from the next frame.
    cfg_log2n = 4'd4; cfg_en = 1'b1;
    for (int i = 0; i < 80; i++) begin
      if (i == 5) cfg_log2n = 4'd6;
      if (i == 79) cfg_en = 1'b0;
      send(32'h400 + 32'(i), (i == 15) || (i == 79), (i == 15) || (i == 79));
    end
    wait_idle();
    compare_q("len_change");
    chk("len_change_early", 64'(err_early), 64'd0);
    chk("len_change_miss", 64'(err_miss), 64'd0);
    pulse_clr();

    // Random backpressure, 256 beats in 32-beat frames.
    rnd_ready = 1'b1;
    cfg_log2n = 4'd5; cfg_en = 1'b1;
    for (int i = 0; i < 256; i++) begin
      if (i == 255) cfg_en = 1'b0;
      send(32'hBEEF_0000 + 32'(i), (i % 32) == 31, (i % 32) == 31);
    end
    wait_idle();
    rnd_ready = 1'b0;
    compare_q("random_ready");
    chk("random_early", 64'(err_early), 64'd0);
    chk("random_miss", 64'(err_miss), 64'd0);
    pulse_clr();

    // Mid-frame reset with beats buffered: everything returns to reset values.
    stall = 1'b1;
    repeat (2) @(posedge aclk);
    #1;
    cfg_log2n = 4'd4; cfg_en = 1'b1;
    send(32'hA5A5_0001, 1'b0, 1'b0);
    send(32'hA5A5_0002, 1'b0, 1'b0);
    chk("stalled_tvalid", 64'(m_tvalid), 64'd1);
    aresetn = 1'b0; cfg_en = 1'b0;
    @(posedge aclk); #1;
    check_reset_vals("midreset");
    aresetn = 1'b1; stall = 1'b0;
    got_q.delete(); exp_q.delete(); exp_ch = 0;
    @(posedge aclk); #1;
    cfg_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i == 15) cfg_en = 1'b0;
      send(32'h500 + 32'(i), i == 15, i == 15);
    end
    wait_idle();
    compare_q("post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
